// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the convolution MAC processing element.
// ACC_W sizing and output saturation live here so every user agrees on them.
package mac_pkg;

    localparam int DEF_K      = 3;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 15;
    localparam int DEF_OUT_W  = 20;

    // Working width for saturation; wide enough for any accumulator this block builds.
    localparam int SAT_W = 128;

    // Accumulator width: full product, growth over the K*K window, 8 bits of channel headroom.
    function automatic int acc_w(input int k, input int data_w);
        return 2 * data_w + $clog2(k * k) + 8;
    endfunction

    // Clamp a signed value into the signed range of an out_w-bit result.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_row_sum.sv
// One row of the window adder tree: K signed products in, one registered
// sign-extended sum out. Holds its value while en is low.
module mac_row_sum
    import mac_pkg::*;
#(
    parameter int K      = DEF_K,
    parameter int PROD_W = 2 * DEF_DATA_W,
    parameter int SUM_W  = acc_w(DEF_K, DEF_DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [K*PROD_W-1:0]     prod,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] sum_d;

    // Sign-extend each product of the row and add them up.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < K; i++) begin
            sum_d = sum_d + SUM_W'($signed(prod[i*PROD_W +: PROD_W]));
        end
    end

    // Row-sum register; advances only when the pipeline is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_d;
        end
    end

endmodule

// File: rtl/conv_mac_pe.sv
// Convolution MAC processing element.
// Each accepted beat is one K*K window of one input channel. The beat is
// multiplied tap-by-tap (stage 1), reduced per row (stage 2), reduced to a
// window sum (stage 3) and folded into the channel accumulator (stage 4).
// When the beat that reached stage 4 was the last channel, the accumulator is
// shifted down by FRAC_W, saturated to OUT_W and presented on mac_output.
// Handshake: a beat transfers on in_valid && in_ready, a result transfers on
// out_valid && out_ready; the whole pipeline advances together on
// en = !out_valid || out_ready, so a stalled output freezes every stage and
// in_ready drops with it.
// Optional build macro: MAC_RELU_EN clamps negative results to zero.
module conv_mac_pe
    import mac_pkg::*;
#(
    parameter int K      = DEF_K,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [K*K*DATA_W-1:0]   ifmap_chunk,
    input  logic [K*K*DATA_W-1:0]   weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        mac_output
);

    localparam int TAPS   = K * K;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_w(K, DATA_W);

    logic en;

    // Beat tags: bit i describes the beat held in stage i+1.
    logic [3:0] valid_q;
    logic [3:0] first_q;
    logic [3:0] last_q;

    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic [TAPS*PROD_W-1:0]   prod_q;
    logic signed [ACC_W-1:0]  row_sum [K];
    logic signed [ACC_W-1:0]  win_d;
    logic signed [ACC_W-1:0]  win_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_shifted;
    logic signed [SAT_W-1:0]  sat_full;
    logic [OUT_W-1:0]         result_d;
    logic                     pixel_done;

    // The first flag is consumed at stage 4 entry; the stage-4 copy rides along unused.
    logic unused_first_tag;
    assign unused_first_tag = first_q[3];

    assign en         = !out_valid || out_ready;
    assign in_ready   = rst || en;
    assign pixel_done = valid_q[3] && last_q[3];

    // Tag shift register: valid/first/last move one stage per enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else if (en) begin
            valid_q <= {valid_q[2:0], in_valid};
            first_q <= {first_q[2:0], in_valid && in_first};
            last_q  <= {last_q[2:0],  in_valid && in_last};
        end
    end

    // Stage 1 products; tap t sits t words below the MSB end of the input vectors.
    for (genvar t = 0; t < TAPS; t++) begin : g_mul
        assign prod_d[t] =
            PROD_W'($signed(ifmap_chunk[(TAPS-1-t)*DATA_W +: DATA_W])) *
            PROD_W'($signed(weight[(TAPS-1-t)*DATA_W +: DATA_W]));
    end

    // Stage 1 register: one full-width product per tap, packed tap 0 at the LSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en) begin
            for (int t = 0; t < TAPS; t++) begin
                prod_q[t*PROD_W +: PROD_W] <= prod_d[t];
            end
        end
    end

    // Stage 2: one registered adder per window row.
    for (genvar r = 0; r < K; r++) begin : g_row
        mac_row_sum #(
            .K      (K),
            .PROD_W (PROD_W),
            .SUM_W  (ACC_W)
        ) u_row_sum (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .prod (prod_q[r*K*PROD_W +: K*PROD_W]),
            .sum  (row_sum[r])
        );
    end

    // Stage 3 combinational reduction of the row sums.
    always_comb begin
        win_d = '0;
        for (int r = 0; r < K; r++) begin
            win_d = win_d + row_sum[r];
        end
    end

    // Stage 3 register: the whole window sum at accumulator width.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (en) begin
            win_q <= win_d;
        end
    end

    // Stage 4 accumulator: restart on a first-channel beat, otherwise keep adding; bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en && valid_q[2]) begin
            if (first_q[2]) begin
                acc_q <= win_q;
            end else begin
                acc_q <= acc_q + win_q;
            end
        end
    end

    // Drop fraction bits (floor), saturate, optionally rectify.
    always_comb begin
        acc_shifted = acc_q >>> FRAC_W;
        sat_full    = saturate(SAT_W'(acc_shifted), OUT_W);
`ifdef MAC_RELU_EN
        result_d    = sat_full[SAT_W-1] ? '0 : OUT_W'(sat_full);
`else
        result_d    = OUT_W'(sat_full);
`endif
    end

    // Output register: load a finished pixel, drop valid once it has been taken, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            mac_output <= '0;
        end else if (en) begin
            out_valid <= pixel_done;
            if (pixel_done) begin
                mac_output <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pe.sv
// Directed bench for conv_mac_pe with the default geometry (3x3, 16-bit data,
// 15 fraction bits, 20-bit output). Results are collected at the falling edge
// whenever a transfer is about to happen and compared to hand-computed values.
module tb_conv_mac_pe;

    localparam int K      = 3;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 15;
    localparam int OUT_W  = 20;
    localparam int TAPS   = K * K;
    localparam int W      = TAPS * DATA_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic [W-1:0]     ifmap_chunk;
    logic [W-1:0]     weight;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] mac_output;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] got_q[$];
    logic [OUT_W-1:0] exp_q[$];

    conv_mac_pe #(
        .K      (K),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_last     (in_last),
        .ifmap_chunk (ifmap_chunk),
        .weight      (weight),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mac_output  (mac_output)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every result that transfers at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(mac_output);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] fill(input logic [DATA_W-1:0] v);
        logic [W-1:0] r;
        for (int t = 0; t < TAPS; t++) r[(TAPS-1-t)*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] set_tap(input logic [W-1:0] vec, input int t,
                                             input logic [DATA_W-1:0] v);
        logic [W-1:0] r;
        r = vec;
        r[(TAPS-1-t)*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    // Expected output for a signed, already saturated value.
    function automatic logic [OUT_W-1:0] exp_val(input int v);
        int x;
        x = v;
`ifdef MAC_RELU_EN
        if (x < 0) x = 0;
`endif
        return OUT_W'(x);
    endfunction

    // ---------------- driver tasks ----------------
    // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [W-1:0] px, input logic [W-1:0] wt,
                             input logic first, input logic last);
        int n;
        in_valid    = 1'b1;
        ifmap_chunk = px;
        weight      = wt;
        in_first    = first;
        in_last     = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_n(input int n, input int limit);
        int c;
        c = 0;
        while (got_q.size() < n && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_first    = 1'b0;
        in_last     = 1'b0;
        ifmap_chunk = '0;
        weight      = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (mac_output !== '0) begin
            errors++;
            $display("FAIL reset_mac_output: got %0d, expected 0", $signed(mac_output));
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_single_pixel();
        int n;
        logic [OUT_W-1:0] exp;
        exp = exp_val(73728);
        got_q.delete();
        send_beat(fill(16'h4000), fill(16'h4000), 1'b1, 1'b1);
        idle(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL single_latency: out_valid after %0d edges, expected 5", n);
        end
        checks++;
        if (mac_output !== exp) begin
            errors++;
            $display("FAIL single_value: got %0d, expected %0d", $signed(mac_output), $signed(exp));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: out_valid=%b one cycle later, expected 0", out_valid);
        end
        idle(3);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d results, expected 1", got_q.size());
        end
    endtask

    task automatic test_negative();
        logic [OUT_W-1:0] exp;
        exp = exp_val(-294903);
        got_q.delete();
        send_beat(fill(16'h8000), fill(16'h7FFF), 1'b1, 1'b1);
        idle(0);
        wait_n(1, 30);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp) begin
            errors++;
            $display("FAIL negative_value: got %0d (n=%0d), expected %0d",
                     $signed(got_q.size() > 0 ? got_q[0] : '0), got_q.size(), $signed(exp));
        end
        idle(2);
    endtask

    task automatic test_saturation();
        logic [OUT_W-1:0] exp;
        exp = exp_val(524287);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_beat(fill(16'h7FFF), fill(16'h7FFF), i == 0, i == 3);
        end
        idle(0);
        wait_n(1, 30);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp) begin
            errors++;
            $display("FAIL pos_saturation: got %0d (n=%0d), expected %0d",
                     $signed(got_q.size() > 0 ? got_q[0] : '0), got_q.size(), $signed(exp));
        end
        exp = exp_val(-524288);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_beat(fill(16'h8000), fill(16'h7FFF), i == 0, i == 3);
        end
        idle(0);
        wait_n(1, 30);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp) begin
            errors++;
            $display("FAIL neg_saturation: got %0d (n=%0d), expected %0d",
                     $signed(got_q.size() > 0 ? got_q[0] : '0), got_q.size(), $signed(exp));
        end
        idle(2);
    endtask

    task automatic test_tap_order_and_floor();
        logic [W-1:0] px;
        logic [W-1:0] wt;
        px = '0;
        for (int t = 0; t < TAPS; t++) px = set_tap(px, t, 16'((t + 1) * 16'h0800));
        wt = set_tap('0, 1, 16'h4000);
        got_q.delete();
        exp_q.delete();
        // tap 1 pixel = 0x1000: 4096*16384 >> 15 = 2048
        send_beat(px, wt, 1'b1, 1'b1);
        exp_q.push_back(exp_val(2048));
        // -1 * 1 floors to -1; +1 * 1 floors to 0
        send_beat(set_tap('0, 0, 16'hFFFF), set_tap('0, 0, 16'h0001), 1'b1, 1'b1);
        exp_q.push_back(exp_val(-1));
        send_beat(set_tap('0, 8, 16'h0001), set_tap('0, 8, 16'h0001), 1'b1, 1'b1);
        exp_q.push_back(exp_val(0));
        idle(0);
        wait_n(3, 30);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL taps_count: got %0d results, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL taps_value[%0d]: got %0d, expected %0d", i,
                         $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
        idle(2);
    endtask

    task automatic test_multi_channel();
        got_q.delete();
        send_beat(fill(16'h4000), fill(16'h4000), 1'b1, 1'b0);
        idle(3);
        send_beat(fill(16'h4000), fill(16'h4000), 1'b0, 1'b0);
        send_beat(fill(16'h4000), fill(16'h4000), 1'b0, 1'b1);
        idle(0);
        wait_n(1, 30);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_val(221184)) begin
            errors++;
            $display("FAIL multi_channel: got %0d (n=%0d), expected 221184",
                     $signed(got_q.size() > 0 ? got_q[0] : '0), got_q.size());
        end
        // No first flag: keeps accumulating onto the finished pixel.
        send_beat(fill(16'h4000), fill(16'h4000), 1'b0, 1'b1);
        idle(0);
        wait_n(2, 30);
        checks++;
        if (got_q.size() != 2 || got_q[1] !== exp_val(294912)) begin
            errors++;
            $display("FAIL continue_acc: got %0d (n=%0d), expected 294912",
                     $signed(got_q.size() > 1 ? got_q[1] : '0), got_q.size());
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_val(1152 * (i + 1)));
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_beat(fill(16'h4000), fill(16'(16'h0100 * (i + 1))), 1'b1, 1'b1);
                end
                idle(0);
            end
            begin
                int n;
                logic [OUT_W-1:0] held;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 40) begin
                    n++;
                    @(negedge clk);
                end
                if (!out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: out_valid=%b after %0d cycles, expected 1", out_valid, n);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = mac_output;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready[%0d]: got %b, expected 0", c, in_ready);
                    end
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_out_valid[%0d]: got %b, expected 1", c, out_valid);
                    end
                    checks++;
                    if (mac_output !== held) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: got %0d, expected %0d", c,
                                 $signed(mac_output), $signed(held));
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_n(6, 60);
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_value[%0d]: got %0d, expected %0d", i,
                         $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
        idle(2);
    endtask

    task automatic test_reset_abort();
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_beat(fill(16'h7FFF), fill(16'h7FFF), i == 0, 1'b0);
        end
        idle(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mac_output !== '0) begin
            errors++;
            $display("FAIL abort_reset_state: out_valid=%b mac_output=%0d, expected 0 and 0",
                     out_valid, $signed(mac_output));
        end
        send_beat(fill(16'h4000), fill(16'h4000), 1'b1, 1'b1);
        idle(12);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_val(73728)) begin
            errors++;
            $display("FAIL abort_output: got %0d (n=%0d), expected only 73728",
                     $signed(got_q.size() > 0 ? got_q[0] : '0), got_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_pixel();
        test_negative();
        test_saturation();
        test_tap_order_and_floor();
        test_multi_channel();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
